multicycle_ctrl: RTL and testbench

Multicycle MIPS control unit: the initiator side of the ALU's `ALUctrlop` interface. Sequences fetch, decode, execute, memory and write-back for add, sub, and, or, slt, nor, addi, lw, sw, beq and j. Drives the 4-bit ALU operation code, datapath mux selects and write strobes, and stalls on a memory-ready handshake. Sits beside the ALU in the multicycle datapath top level.

---
 rtl/mc_pkg.sv | 41 ++++
 rtl/alu_op_decode.sv | 27 ++
 rtl/multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// R-type function codes and ALU operation codes.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExec,
        StRwb,
        StBranch,
        StJump,
        StAddiEx,
        StAddiWb
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnNor = 6'b100111;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1000;

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct to ALU operation decode; funct_ok flags the supported subset.
module alu_op_decode
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       funct_ok
);

    always_comb begin
        alu_op   = AluAdd;
        funct_ok = 1'b1;
        case (funct)
            FnAdd:   alu_op = AluAdd;
            FnSub:   alu_op = AluSub;
            FnAnd:   alu_op = AluAnd;
            FnOr:    alu_op = AluOr;
            FnSlt:   alu_op = AluSlt;
            FnNor:   alu_op = AluNor;
            default: begin
                alu_op   = AluAdd;
                funct_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives the ALU operation code plus datapath selects and strobes.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic [3:0]  ALUctrlop,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        illegal,
    output logic [31:0] instr_retired
);

    state_e     state_q;
    logic [3:0] fn_alu_op;
    logic       fn_ok;
    logic       op_legal;
    logic       retire;

    alu_op_decode u_alu_op_decode (
        .funct    (funct),
        .alu_op   (fn_alu_op),
        .funct_ok (fn_ok)
    );

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OpLw, OpSw, OpBeq, OpJ, OpAddi: op_legal = 1'b1;
            OpRtype:                        op_legal = fn_ok;
            default:                        op_legal = 1'b0;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state_q)
            StMemWb, StRwb, StBranch, StJump, StAddiWb: retire = 1'b1;
            StMemWr:                                    retire = mem_ready;
            default:                                    retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StFetch;
            instr_retired <= '0;
        end else begin
            if (retire) begin
                instr_retired <= instr_retired + 32'd1;
            end
            unique case (state_q)
                StFetch: if (mem_ready) state_q <= StDecode;
                StDecode: begin
                    if (!op_legal) begin
                        state_q <= StFetch;
                    end else begin
                        case (opcode)
                            OpLw, OpSw: state_q <= StMemAdr;
                            OpRtype:    state_q <= StExec;
                            OpBeq:      state_q <= StBranch;
                            OpJ:        state_q <= StJump;
                            default:    state_q <= StAddiEx;
                        endcase
                    end
                end
                StMemAdr: state_q <= (opcode == OpLw) ? StMemRd : StMemWr;
                StMemRd:  if (mem_ready) state_q <= StMemWb;
                StMemWr:  if (mem_ready) state_q <= StFetch;
                StExec:   state_q <= StRwb;
                StAddiEx: state_q <= StAddiWb;
                default:  state_q <= StFetch;
            endcase
        end
    end

    // Moore decode of state; held quiet while reset is asserted so an aborted
    // instruction leaves no stray strobe behind.
    always_comb begin
        ALUctrlop = AluAdd;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSource  = 2'b00;
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        illegal   = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StFetch: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                StDecode: begin
                    ALUSrcB = 2'b11;
                    illegal = ~op_legal;
                end
                StMemAdr, StAddiEx: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                StMemRd: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                StMemWb: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                StMemWr: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                StExec: begin
                    ALUSrcA   = 1'b1;
                    ALUctrlop = fn_alu_op;
                end
                StRwb: begin
                    RegWrite  = 1'b1;
                    RegDst    = 1'b1;
                    ALUctrlop = fn_alu_op;
                end
                StBranch: begin
                    ALUSrcA   = 1'b1;
                    ALUctrlop = AluSub;
                    PCSource  = 2'b01;
                    PCWrite   = Zero;
                end
                StJump: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                StAddiWb: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an
// instruction-level model (latency, strobe counts, retire count).
module tb_multicycle_ctrl;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        Zero;
    logic        mem_ready;
    logic [3:0]  ALUctrlop;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite;
    logic        RegDst, MemtoReg, RegWrite, illegal;
    logic [31:0] instr_retired;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_retired = '0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .Zero          (Zero),
        .mem_ready     (mem_ready),
        .ALUctrlop     (ALUctrlop),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .PCSource      (PCSource),
        .PCWrite       (PCWrite),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .RegWrite      (RegWrite),
        .illegal       (illegal),
        .instr_retired (instr_retired)
    );

    function automatic bit ref_fn_ok(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    endfunction

    function automatic logic [3:0] ref_fn_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1000;
            default:   return 4'b0010;
        endcase
    endfunction

    // Runs one instruction from its FETCH cycle; nf stall cycles in fetch,
    // nm stall cycles in the memory access (lw/sw only).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int nf, input int nm, input string name);
        bit is_lw, is_sw, is_r, is_beq, is_j, is_addi, legal, is_mem;
        int base, len;
        int regw = 0, memw_done = 0, memw_all = 0, pcw = 0, irw = 0, ill = 0;
        int exp_pcw;
        is_lw   = (op == 6'b100011);
        is_sw   = (op == 6'b101011);
        is_r    = (op == 6'b000000) && ref_fn_ok(fn);
        is_beq  = (op == 6'b000100);
        is_j    = (op == 6'b000010);
        is_addi = (op == 6'b001000);
        legal   = is_lw || is_sw || is_r || is_beq || is_j || is_addi;
        is_mem  = is_lw || is_sw;
        base = is_lw ? 5 : (is_sw || is_r || is_addi) ? 4 : (is_beq || is_j) ? 3 : 2;
        len  = base + nf + (is_mem ? nm : 0);
        exp_pcw = 1 + (is_j ? 1 : 0) + ((is_beq && z) ? 1 : 0);
        opcode = op;
        funct  = fn;
        Zero   = z;
        for (int i = 0; i < len; i++) begin
            mem_ready = !(i < nf) && !(is_mem && i >= nf + 3 && i < nf + 3 + nm);
            @(negedge clk);
            regw      += int'(RegWrite);
            memw_all  += int'(MemWrite);
            memw_done += int'(MemWrite && mem_ready);
            pcw       += int'(PCWrite);
            irw       += int'(IRWrite);
            ill       += int'(illegal);
            if (RegWrite) begin
                total++;
                if (MemtoReg !== is_lw || RegDst !== is_r) begin
                    bad++;
                    $display("FAIL %s wb_sel: MemtoReg=%b RegDst=%b want %b %b",
                             name, MemtoReg, RegDst, is_lw, is_r);
                end
            end
            if (i == nf + 2 && is_r) begin
                total++;
                if (ALUctrlop !== ref_fn_alu(fn) || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
                    bad++;
                    $display("FAIL %s exec: op=%b srca=%b srcb=%b want %b 1 00",
                             name, ALUctrlop, ALUSrcA, ALUSrcB, ref_fn_alu(fn));
                end
            end
            if (i == nf + 2 && is_beq) begin
                total++;
                if (ALUctrlop !== 4'b0110 || PCSource !== 2'b01 || PCWrite !== z) begin
                    bad++;
                    $display("FAIL %s branch: op=%b pcsrc=%b pcw=%b want 0110 01 %b",
                             name, ALUctrlop, PCSource, PCWrite, z);
                end
            end
            if (i == nf + 1 && !legal) begin
                total++;
                if (illegal !== 1'b1) begin
                    bad++;
                    $display("FAIL %s illegal_pulse: got %b want 1", name, illegal);
                end
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (regw !== ((is_lw || is_r || is_addi) ? 1 : 0) || memw_done !== (is_sw ? 1 : 0)
            || memw_all !== (is_sw ? nm + 1 : 0)) begin
            bad++;
            $display("FAIL %s writes: regw=%0d memw=%0d memw_all=%0d", name, regw, memw_done,
                     memw_all);
        end
        total++;
        if (pcw !== exp_pcw || irw !== 1 || ill !== (legal ? 0 : 1)) begin
            bad++;
            $display("FAIL %s strobes: pcw=%0d irw=%0d ill=%0d want %0d 1 %0d",
                     name, pcw, irw, ill, exp_pcw, legal ? 0 : 1);
        end
        if (legal) exp_retired = exp_retired + 32'd1;
        mem_ready = 1'b1;
        total++;
        if (MemRead !== 1'b1 || IorD !== 1'b0 || ALUSrcB !== 2'b01 || RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL %s next_fetch: MemRead=%b IorD=%b ALUSrcB=%b", name, MemRead, IorD,
                     ALUSrcB);
        end
        total++;
        if (instr_retired !== exp_retired) begin
            bad++;
            $display("FAIL %s retired: got %h want %h", name, instr_retired, exp_retired);
        end
    endtask

    task automatic check_quiet(input string name);
        total++;
        if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal} !== 6'b0
            || {ALUSrcA, ALUSrcB, PCSource, IorD, RegDst, MemtoReg} !== 8'b0
            || ALUctrlop !== 4'b0010 || instr_retired !== 32'd0) begin
            bad++;
            $display("FAIL %s: strobes=%b selects=%b alu=%b retired=%h want 0 0 0010 0", name,
                     {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal},
                     {ALUSrcA, ALUSrcB, PCSource, IorD, RegDst, MemtoReg}, ALUctrlop,
                     instr_retired);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'b000000;
        funct = 6'b100000;
        Zero = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset_state");
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_retired = '0;
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "rtype_add");
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, "lw_stall");
        run_instr(6'b101011, 6'b000000, 1'b0, 2, 1, "sw_stall");
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0, "addi");
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, "jump");
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_taken");
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_not_taken");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'b100000, 1'b0, 0, 0, "illegal_op");
        run_instr(6'b000000, 6'b000000, 1'b0, 1, 0, "illegal_funct");
    endtask

    task automatic test_reset_mid();
        opcode = 6'b101011;
        funct = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3);
            @(negedge clk);
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        total++;
        if (MemWrite !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_memwr: MemWrite=%b want 1", MemWrite);
        end
        #1 rst_n = 1'b0;
        #1 check_quiet("reset_mid_abort");
        @(posedge clk);
        #1 check_quiet("reset_mid_held");
        rst_n = 1'b1;
        mem_ready = 1'b1;
        exp_retired = '0;
    endtask

    task automatic test_wrap_sweep();
        logic [5:0] fns [6];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        force dut.instr_retired = 32'hFFFF_FFFE;
        #1 release dut.instr_retired;
        exp_retired = 32'hFFFF_FFFE;
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, "wrap_ffffffff");
        run_instr(6'b000000, fns[0], 1'b0, 0, 0, "wrap_zero");
        for (int k = 1; k < 6; k++) begin
            run_instr(6'b000000, fns[k], 1'b0, 0, 0, $sformatf("funct_%b", fns[k]));
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        logic [5:0] fns [7];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b110001};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000111};
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(6)];
            fn = fns[$urandom_range(6)];
            run_instr(op, fn, 1'($urandom_range(1)), $urandom_range(2), $urandom_range(3),
                      $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_beq();
        test_illegal();
        test_reset_mid();
        test_wrap_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
